mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port of the multi-cycle CPU between two requesters: instruction fetch (IF state) and data access (MEM state).
- Arbitrates between them, sequences one memory transaction at a time over a req/ack handshake with variable memory latency, and returns read data to the winner.
- A watchdog aborts memory accesses that are never acknowledged.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 16, maximum cycles to wait for mem_ack; 0 disables the watchdog.
- PRIO_DATA, 1: 1 = data port wins ties; 0 = round-robin on ties.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  one-cycle pulse: fetch request accepted.
- if_rvalid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  DATA_W  fetched word.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_gnt  out  1  one-cycle pulse: data request accepted.
- d_rvalid  out  1  one-cycle pulse: read data valid, or write complete.
- d_rdata  out  DATA_W  read data.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ack  in  1  memory completion; mem_rdata valid in the same cycle.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  1 whenever state != IDLE.
- timeout_err  out  1  sticky watchdog error flag.

Behaviour:
- All outputs are registered.
- States: IDLE, I_ACC, D_ACC.
- Reset (rst=0, asynchronous): state=IDLE; every output=0; timeout counter=0; last_grant=IF.
- IDLE:
  - Sample requests at each edge.
  - Only if_req → I_ACC. Only d_req → D_ACC.
  - Both: PRIO_DATA=1 → D_ACC. PRIO_DATA=0 → grant the port not in last_grant, then update last_grant.
  - mem_ack in IDLE is ignored.
- On entry to x_ACC, all at the same edge:
  - Latch address, and for data also we/wdata, onto mem_addr/mem_we/mem_wdata.
  - mem_req←1; x_gnt←1 for exactly one cycle; counter←0.
  - mem_we is always 0 for fetches.
- In x_ACC, mem_req and all mem_* outputs stay stable until completion.
- Completion: the edge where mem_ack=1.
  - mem_req←0; x_rvalid←1 for one cycle; state←IDLE.
  - Reads: x_rdata←mem_rdata.
  - Writes: d_rdata holds its previous value.
- Watchdog (TIMEOUT>0):
  - Counter increments each ACC cycle without mem_ack.
  - At the edge where counter==TIMEOUT-1 and mem_ack=0: abort. mem_req←0; x_rvalid←1; x_rdata←0; timeout_err←1 (held until reset); state←IDLE.
  - mem_ack in the abort cycle counts as a normal completion.
- Latency:
  - Request sampled at edge T → gnt and mem_req high in cycle T+1.
  - mem_ack high in cycle T+1 → rvalid in cycle T+2.
  - Next request may be sampled at the edge ending T+2, so back-to-back accesses take a minimum of 2 cycles each.
- Requester holding req after its gnt:
  - Treated as a new request at the next IDLE sample.
  - The control FSM must drop req after gnt.
- Reset asserted mid-access: immediate return to IDLE, mem_req=0, no rvalid issued.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100; memory acks 3 cycles after mem_req with 0x2002_0001. Expect if_gnt one cycle after req; mem_addr=0x100, mem_we=0; if_rvalid one cycle after ack with if_rdata=0x2002_0001; busy=0 afterwards.
- Tie, PRIO_DATA=1: if_req and d_req rise together (d_we=0, d_addr=0x40). Expect d_gnt first. After d_rvalid, if_gnt follows two cycles after ack; no overlap of the two grants.
- Round-robin, PRIO_DATA=0: three consecutive simultaneous ties. Expect grant order D, I, D (last_grant reset=IF).
- Data write: d_we=1, d_addr=0x80, d_wdata=0xDEADBEEF, immediate ack. Expect mem_we=1 with stable addr/data until ack; d_rvalid pulse; d_rdata unchanged; no if_rvalid.
- Watchdog, TIMEOUT=4: memory never acks a fetch. Expect mem_req high for exactly 4 cycles, then if_rvalid with if_rdata=0 and timeout_err=1 sticky. A later normal access completes with timeout_err still 1.
- Reset mid-access: rst=0 two cycles after mem_req rises. Expect mem_req, busy and gnt flags 0 immediately; no rvalid after release; a fresh request is served normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the CPU's single memory port between instruction
// fetch and data access, one req/ack transaction at a time, with a watchdog
// that aborts accesses the memory never acknowledges.
module mem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 16,
    parameter bit PRIO_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              timeout_err
);

    // Counter only has to reach TIMEOUT-1, the cycle in which the abort fires.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        I_ACC,
        D_ACC
    } state_t;

    state_t            state_q, state_d;
    logic              lastGrantData_q, lastGrantData_d;
    logic [CNT_W-1:0]  timeoutCnt_q, timeoutCnt_d;
    logic              ifGnt_q, ifGnt_d;
    logic              ifRvalid_q, ifRvalid_d;
    logic [DATA_W-1:0] ifRdata_q, ifRdata_d;
    logic              dGnt_q, dGnt_d;
    logic              dRvalid_q, dRvalid_d;
    logic [DATA_W-1:0] dRdata_q, dRdata_d;
    logic              memReq_q, memReq_d;
    logic              memWe_q, memWe_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [DATA_W-1:0] memWdata_q, memWdata_d;
    logic              busy_q, busy_d;
    logic              timeoutErr_q, timeoutErr_d;
    logic              pickData;
    logic              abortNow;

    // Next-state logic: arbitration in IDLE, completion/abort while accessing.
    always_comb begin
        state_d         = state_q;
        lastGrantData_d = lastGrantData_q;
        timeoutCnt_d    = timeoutCnt_q;
        ifGnt_d         = 1'b0;
        ifRvalid_d      = 1'b0;
        ifRdata_d       = ifRdata_q;
        dGnt_d          = 1'b0;
        dRvalid_d       = 1'b0;
        dRdata_d        = dRdata_q;
        memReq_d        = memReq_q;
        memWe_d         = memWe_q;
        memAddr_d       = memAddr_q;
        memWdata_d      = memWdata_q;
        busy_d          = busy_q;
        timeoutErr_d    = timeoutErr_q;
        pickData        = 1'b0;
        abortNow        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (if_req && d_req) begin
                    pickData = PRIO_DATA ? 1'b1 : !lastGrantData_q;
                    if (!PRIO_DATA) begin
                        lastGrantData_d = pickData;
                    end
                end else begin
                    pickData = d_req;
                end
                if (if_req || d_req) begin
                    memReq_d     = 1'b1;
                    busy_d       = 1'b1;
                    timeoutCnt_d = '0;
                    if (pickData) begin
                        state_d    = D_ACC;
                        dGnt_d     = 1'b1;
                        memAddr_d  = d_addr;
                        memWe_d    = d_we;
                        memWdata_d = d_wdata;
                    end else begin
                        state_d   = I_ACC;
                        ifGnt_d   = 1'b1;
                        memAddr_d = if_addr;
                        memWe_d   = 1'b0;
                    end
                end
            end
            I_ACC, D_ACC: begin
                abortNow = !mem_ack && (TIMEOUT > 0) && (timeoutCnt_q == CNT_LAST);
                if (mem_ack || abortNow) begin
                    state_d  = IDLE;
                    memReq_d = 1'b0;
                    busy_d   = 1'b0;
                    if (abortNow) begin
                        timeoutErr_d = 1'b1;
                    end
                    if (state_q == I_ACC) begin
                        ifRvalid_d = 1'b1;
                        ifRdata_d  = abortNow ? '0 : mem_rdata;
                    end else begin
                        dRvalid_d = 1'b1;
                        if (abortNow) begin
                            dRdata_d = '0;
                        end else if (!memWe_q) begin
                            dRdata_d = mem_rdata;
                        end
                    end
                end else begin
                    timeoutCnt_d = timeoutCnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset clears everything, last grant = fetch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            lastGrantData_q <= 1'b0;
            timeoutCnt_q    <= '0;
            ifGnt_q         <= 1'b0;
            ifRvalid_q      <= 1'b0;
            ifRdata_q       <= '0;
            dGnt_q          <= 1'b0;
            dRvalid_q       <= 1'b0;
            dRdata_q        <= '0;
            memReq_q        <= 1'b0;
            memWe_q         <= 1'b0;
            memAddr_q       <= '0;
            memWdata_q      <= '0;
            busy_q          <= 1'b0;
            timeoutErr_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            lastGrantData_q <= lastGrantData_d;
            timeoutCnt_q    <= timeoutCnt_d;
            ifGnt_q         <= ifGnt_d;
            ifRvalid_q      <= ifRvalid_d;
            ifRdata_q       <= ifRdata_d;
            dGnt_q          <= dGnt_d;
            dRvalid_q       <= dRvalid_d;
            dRdata_q        <= dRdata_d;
            memReq_q        <= memReq_d;
            memWe_q         <= memWe_d;
            memAddr_q       <= memAddr_d;
            memWdata_q      <= memWdata_d;
            busy_q          <= busy_d;
            timeoutErr_q    <= timeoutErr_d;
        end
    end

    assign if_gnt      = ifGnt_q;
    assign if_rvalid   = ifRvalid_q;
    assign if_rdata    = ifRdata_q;
    assign d_gnt       = dGnt_q;
    assign d_rvalid    = dRvalid_q;
    assign d_rdata     = dRdata_q;
    assign mem_req     = memReq_q;
    assign mem_we      = memWe_q;
    assign mem_addr    = memAddr_q;
    assign mem_wdata   = memWdata_q;
    assign busy        = busy_q;
    assign timeout_err = timeoutErr_q;

endmodule
